layer_flatten: RTL and testbench

- Downstream stage of the convolution/max-pool engine.
- Once both pooled feature maps are complete (layer-1 memory kernel 0 at csel=3, kernel 1 at csel=4; 32x32 each), it reads them through the shared layer-memory bus.
- It writes the interleaved flatten vector to layer-2 memory (csel=5): element 2k is kernel0[k] and element 2k+1 is kernel1[k].
- The top-level sequencer launches it with a start pulse and waits for done.

---
 rtl/layer_flatten_pkg.sv | 34 +++
 rtl/layer_flatten.sv | 133 +++++++++++++
 tb/tb_layer_flatten.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_flatten_pkg.sv
// Shared layer-memory constants and types for the conv/pool and flatten stages.
package layer_flatten_pkg;

  // Layer-memory bus geometry
  localparam int DATA_W      = 20;
  localparam int ADDR_W      = 12;
  localparam int POOL_N_ELEM = 1024;

  // Bank select codes on the shared layer-memory bus
  typedef enum logic [2:0] {
    SEL_NONE  = 3'd0,
    SEL_L0_K0 = 3'd1,
    SEL_L0_K1 = 3'd2,
    SEL_L1_K0 = 3'd3,
    SEL_L1_K1 = 3'd4,
    SEL_L2    = 3'd5
  } csel_e;

  // Banks used by the flatten stage: two pooled maps in, one flatten vector out
  localparam logic [2:0] SEL_K0  = SEL_L1_K0;
  localparam logic [2:0] SEL_K1  = SEL_L1_K1;
  localparam logic [2:0] SEL_OUT = SEL_L2;

  // Flatten sequencer states: two reads then two writes per element pair
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD0  = 3'd1,
    ST_RD1  = 3'd2,
    ST_WR0  = 3'd3,
    ST_WR1  = 3'd4,
    ST_FIN  = 3'd5
  } flat_state_e;

endpackage

// File: rtl/layer_flatten.sv
// Flatten stage: interleaves the two pooled maps into the layer-2 memory.
// Element 2k of the output is kernel0[k], element 2k+1 is kernel1[k].
module layer_flatten
  import layer_flatten_pkg::*;
#(
  parameter int N_ELEM = POOL_N_ELEM
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              crd,
  output logic [ADDR_W-1:0] caddr_rd,
  input  logic [DATA_W-1:0] cdata_rd,
  output logic              cwr,
  output logic [ADDR_W-1:0] caddr_wr,
  output logic [DATA_W-1:0] cdata_wr,
  output logic [2:0]        csel
);

  localparam int IDX_W = $clog2(N_ELEM);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ELEM - 1);

  flat_state_e       r_state;
  flat_state_e       w_stateNext;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_d0;
  logic [DATA_W-1:0] r_d1;
  logic              r_busy;
  logic              r_done;

  logic              w_lastIdx;
  logic [ADDR_W-1:0] w_rdAddr;
  logic [ADDR_W-1:0] w_wrAddrEven;
  logic [ADDR_W-1:0] w_wrAddrOdd;

  // The terminal compare is on the last element so idx never wraps mid-run;
  // write addresses are the element index with the kernel number as LSB.
  assign w_lastIdx    = (r_idx == IDX_LAST);
  assign w_rdAddr     = ADDR_W'(r_idx);
  assign w_wrAddrEven = ADDR_W'({r_idx, 1'b0});
  assign w_wrAddrOdd  = ADDR_W'({r_idx, 1'b1});

  // State register; reset drops any run in progress straight back to idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic: start only matters in idle, so pulses while running are ignored
  always_comb begin
    w_stateNext = r_state;
    unique case (r_state)
      ST_IDLE: if (start) w_stateNext = ST_RD0;
      ST_RD0:  w_stateNext = ST_RD1;
      ST_RD1:  w_stateNext = ST_WR0;
      ST_WR0:  w_stateNext = ST_WR1;
      ST_WR1:  w_stateNext = w_lastIdx ? ST_FIN : ST_RD0;
      ST_FIN:  w_stateNext = ST_IDLE;
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // Datapath: element counter, the two read-data holding registers, busy and done.
  // Read data arrives one cycle after its strobe, so kernel0 data is caught in RD1
  // and kernel1 data in WR0; done is registered so it lines up with busy falling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx  <= '0;
      r_d0   <= '0;
      r_d1   <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == ST_FIN);
      unique case (r_state)
        ST_IDLE: if (start) r_busy <= 1'b1;
        ST_RD0:  ;
        ST_RD1:  r_d0 <= cdata_rd;
        ST_WR0:  r_d1 <= cdata_rd;
        ST_WR1:  if (!w_lastIdx) r_idx <= r_idx + IDX_W'(1);
        ST_FIN: begin
          r_busy <= 1'b0;
          r_idx  <= '0;
        end
        default: ;
      endcase
    end
  end

  // Bus outputs are decoded only from registered state, never from inputs
  always_comb begin
    crd      = 1'b0;
    cwr      = 1'b0;
    csel     = SEL_NONE;
    caddr_rd = '0;
    caddr_wr = '0;
    cdata_wr = '0;
    unique case (r_state)
      ST_RD0: begin
        crd      = 1'b1;
        csel     = SEL_K0;
        caddr_rd = w_rdAddr;
      end
      ST_RD1: begin
        crd      = 1'b1;
        csel     = SEL_K1;
        caddr_rd = w_rdAddr;
      end
      ST_WR0: begin
        cwr      = 1'b1;
        csel     = SEL_OUT;
        caddr_wr = w_wrAddrEven;
        cdata_wr = r_d0;
      end
      ST_WR1: begin
        cwr      = 1'b1;
        csel     = SEL_OUT;
        caddr_wr = w_wrAddrOdd;
        cdata_wr = r_d1;
      end
      default: ;
    endcase
  end

  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_layer_flatten.sv
// Directed bench for layer_flatten: memory models for the pooled maps and L2,
// cycle checks of the first element, full-map checks, start abuse and mid-run reset.
module tb_layer_flatten;
  import layer_flatten_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              busy;
  logic              done;
  logic              crd;
  logic [ADDR_W-1:0] caddr_rd;
  logic [DATA_W-1:0] cdata_rd;
  logic              cwr;
  logic [ADDR_W-1:0] caddr_wr;
  logic [DATA_W-1:0] cdata_wr;
  logic [2:0]        csel;

  logic [DATA_W-1:0] memK0 [1024];
  logic [DATA_W-1:0] memK1 [1024];
  logic [DATA_W-1:0] memL2 [2048];

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int doneCount = 0;
  int protoErr = 0;
  int seqErr = 0;
  int highAddrErr = 0;
  int expWrAddr = 0;
  int maxWrAddr = -1;

  layer_flatten dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .crd      (crd),
    .caddr_rd (caddr_rd),
    .cdata_rd (cdata_rd),
    .cwr      (cwr),
    .caddr_wr (caddr_wr),
    .cdata_wr (cdata_wr),
    .csel     (csel)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Free-running cycle counter used to measure latency
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous layer memory: data for a read strobe shows up the following cycle;
  // when nothing is read the bus carries junk the DUT must not capture
  always @(posedge clk) begin
    if (crd && csel == SEL_K0)      cdata_rd <= memK0[caddr_rd[9:0]];
    else if (crd && csel == SEL_K1) cdata_rd <= memK1[caddr_rd[9:0]];
    else                            cdata_rd <= 20'hA5A5A;
  end

  // Bus monitor: records L2 writes and flags protocol or ordering problems
  always @(negedge clk) begin
    if (reset) begin
      expWrAddr = 0;
    end else begin
      if (crd && cwr) begin
        protoErr++;
        $display("[TB] FAIL proto_rd_wr_overlap at cycle %0d", cyc);
      end
      if (crd && csel != SEL_K0 && csel != SEL_K1) begin
        protoErr++;
        $display("[TB] FAIL proto_rd_csel got %0d want 3 or 4", csel);
      end
      if (cwr && csel != SEL_OUT) begin
        protoErr++;
        $display("[TB] FAIL proto_wr_csel got %0d want 5", csel);
      end
      if (cwr) begin
        if (caddr_wr >= 12'd2048) begin
          highAddrErr++;
          $display("[TB] FAIL wr_addr_range got %0d want below 2048", caddr_wr);
        end else begin
          memL2[caddr_wr[10:0]] = cdata_wr;
        end
        if (int'(caddr_wr) != expWrAddr) begin
          seqErr++;
          $display("[TB] FAIL wr_sequence got %0d want %0d", caddr_wr, expWrAddr);
        end
        expWrAddr = int'(caddr_wr) + 1;
        if (int'(caddr_wr) > maxWrAddr) maxWrAddr = int'(caddr_wr);
      end
      if (done) begin
        doneCount++;
        expWrAddr = 0;
      end
    end
  end

  // Fill both pooled maps with a pattern and poison L2 with a sentinel
  task automatic applyStimulus(input int pattern);
    for (int k = 0; k < 1024; k++) begin
      if (pattern == 0) begin
        memK0[k] = 20'(k);
        memK1[k] = 20'hFFFFF - 20'(k);
      end else begin
        memK0[k] = 20'h40000 | 20'(k);
        memK1[k] = 20'hC0000 + 20'(k);
      end
    end
    if (pattern == 0) begin
      memK0[0]    = 20'h12345;
      memK1[0]    = 20'h80000;
      memK0[1023] = 20'h7FFFF;
    end
    for (int i = 0; i < 2048; i++) memL2[i] = 20'h33333;
  endtask

  // Count L2 entries that differ from the interleaved pooled maps
  function automatic int countL2Bad(output int firstBad);
    int bad;
    logic [DATA_W-1:0] e;
    bad = 0;
    firstBad = -1;
    for (int i = 0; i < 2048; i++) begin
      e = (i % 2 == 1) ? memK1[i / 2] : memK0[i / 2];
      if (memL2[i] !== e) begin
        if (bad == 0) firstBad = i;
        bad++;
      end
    end
    return bad;
  endfunction

  // Wait for done with a cycle budget; reports the cycle and busy one cycle earlier
  task automatic waitDone(output logic ok, output int doneCyc, output logic prevBusy);
    logic pb;
    ok = 1'b0;
    doneCyc = 0;
    pb = busy;
    prevBusy = 1'b0;
    for (int n = 0; n < 6000; n++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        doneCyc = cyc;
        prevBusy = pb;
        break;
      end
      pb = busy;
    end
  endtask

  task automatic test_reset();
    logic [48:0] obs;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    obs = {crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr};
    nvec++;
    if (obs !== 49'd0) begin
      nerr++;
      $display("[TB] FAIL reset_bus got %h want 0", obs);
    end
    nvec++;
    if ({busy, done} !== 2'b00) begin
      nerr++;
      $display("[TB] FAIL reset_busy_done got %b want 00", {busy, done});
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    nvec++;
    if ({busy, done, crd, cwr} !== 4'b0000) begin
      nerr++;
      $display("[TB] FAIL idle_after_reset got %b want 0000", {busy, done, crd, cwr});
    end
  endtask

  task automatic test_full_map();
    logic [48:0] obs;
    logic [48:0] exp [5];
    int rd0Cyc, doneCyc, bad, firstBad;
    logic ok, prevBusy;
    exp[0] = {1'b1, 1'b0, 3'd3, 12'd0, 12'd0, 20'h00000};
    exp[1] = {1'b1, 1'b0, 3'd4, 12'd0, 12'd0, 20'h00000};
    exp[2] = {1'b0, 1'b1, 3'd5, 12'd0, 12'd0, 20'h12345};
    exp[3] = {1'b0, 1'b1, 3'd5, 12'd0, 12'd1, 20'h80000};
    exp[4] = {1'b1, 1'b0, 3'd3, 12'd1, 12'd0, 20'h00000};
    applyStimulus(0);
    doneCount = 0;
    maxWrAddr = -1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rd0Cyc = cyc;
    for (int s = 0; s < 5; s++) begin
      obs = {crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr};
      nvec++;
      if (obs !== exp[s]) begin
        nerr++;
        $display("[TB] FAIL elem0_step%0d got %h want %h", s, obs, exp[s]);
      end
      if (s < 4) @(negedge clk);
    end
    nvec++;
    if (busy !== 1'b1) begin
      nerr++;
      $display("[TB] FAIL busy_running got %b want 1", busy);
    end
    waitDone(ok, doneCyc, prevBusy);
    nvec++;
    if (!ok) begin
      nerr++;
      $display("[TB] FAIL done_timeout got none want done");
    end
    nvec++;
    if (doneCyc - rd0Cyc != 4097) begin
      nerr++;
      $display("[TB] FAIL done_latency got %0d want 4097", doneCyc - rd0Cyc);
    end
    nvec++;
    if ({prevBusy, busy} !== 2'b10) begin
      nerr++;
      $display("[TB] FAIL busy_fall got %b want 10", {prevBusy, busy});
    end
    @(negedge clk);
    nvec++;
    if (done !== 1'b0) begin
      nerr++;
      $display("[TB] FAIL done_width got %b want 0", done);
    end
    repeat (5) @(negedge clk);
    nvec++;
    if (doneCount != 1) begin
      nerr++;
      $display("[TB] FAIL done_count got %0d want 1", doneCount);
    end
    nvec++;
    if (maxWrAddr != 2047 || highAddrErr != 0) begin
      nerr++;
      $display("[TB] FAIL max_wr_addr got %0d (range errs %0d) want 2047", maxWrAddr, highAddrErr);
    end
    nvec++;
    if (memL2[2046] !== 20'h7FFFF || memL2[2047] !== 20'hFFC00) begin
      nerr++;
      $display("[TB] FAIL last_pair got %h %h want 7ffff ffc00", memL2[2046], memL2[2047]);
    end
    bad = countL2Bad(firstBad);
    nvec++;
    if (bad != 0) begin
      nerr++;
      $display("[TB] FAIL l2_full got %0d bad (first %0d) want 0", bad, firstBad);
    end
  endtask

  task automatic test_start_hold();
    int doneCyc, bad, firstBad;
    logic ok, prevBusy, seen;
    applyStimulus(0);
    doneCount = 0;
    seqErr = 0;
    @(negedge clk);
    start = 1'b1;
    repeat (10) @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 3000 && !seen; n++) begin
      @(negedge clk);
      if (crd && caddr_rd == 12'd500) seen = 1'b1;
    end
    nvec++;
    if (!seen) begin
      nerr++;
      $display("[TB] FAIL reach_idx500 got none want read of 500");
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(ok, doneCyc, prevBusy);
    nvec++;
    if (!ok) begin
      nerr++;
      $display("[TB] FAIL hold_done_timeout got none want done");
    end
    repeat (5) @(negedge clk);
    nvec++;
    if (doneCount != 1 || busy !== 1'b0) begin
      nerr++;
      $display("[TB] FAIL single_run got %0d runs busy %b want 1 runs busy 0", doneCount, busy);
    end
    nvec++;
    if (seqErr != 0) begin
      nerr++;
      $display("[TB] FAIL addr_sequential got %0d errs want 0", seqErr);
    end
    bad = countL2Bad(firstBad);
    nvec++;
    if (bad != 0) begin
      nerr++;
      $display("[TB] FAIL hold_l2 got %0d bad (first %0d) want 0", bad, firstBad);
    end
  endtask

  task automatic test_reset_midrun();
    int doneCyc, bad, firstBad;
    logic ok, prevBusy, seen;
    logic [48:0] obs;
    applyStimulus(1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 3000 && !seen; n++) begin
      @(negedge clk);
      if (cwr && caddr_wr == 12'd600) seen = 1'b1;
    end
    nvec++;
    if (!seen) begin
      nerr++;
      $display("[TB] FAIL reach_idx300 got none want write of 600");
    end
    reset = 1'b1;
    @(negedge clk);
    obs = {crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr};
    nvec++;
    if (obs !== 49'd0 || {busy, done} !== 2'b00) begin
      nerr++;
      $display("[TB] FAIL midrun_reset got %h %b want 0 00", obs, {busy, done});
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    nvec++;
    if ({busy, crd, cwr} !== 3'b000) begin
      nerr++;
      $display("[TB] FAIL idle_after_midrun got %b want 000", {busy, crd, cwr});
    end
    for (int i = 0; i < 2048; i++) memL2[i] = 20'h33333;
    doneCount = 0;
    seqErr = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(ok, doneCyc, prevBusy);
    nvec++;
    if (!ok) begin
      nerr++;
      $display("[TB] FAIL rerun_done_timeout got none want done");
    end
    repeat (3) @(negedge clk);
    nvec++;
    if (doneCount != 1 || seqErr != 0) begin
      nerr++;
      $display("[TB] FAIL rerun_runs got %0d runs %0d seq errs want 1 0", doneCount, seqErr);
    end
    bad = countL2Bad(firstBad);
    nvec++;
    if (bad != 0) begin
      nerr++;
      $display("[TB] FAIL rerun_l2 got %0d bad (first %0d) want 0", bad, firstBad);
    end
  endtask

  task automatic checkOutput();
    nvec++;
    if (protoErr != 0 || highAddrErr != 0) begin
      nerr++;
      $display("[TB] FAIL protocol got %0d proto %0d range errs want 0", protoErr, highAddrErr);
    end
  endtask

  // Scenario sequence
  initial begin
    reset = 1'b1;
    start = 1'b0;
    test_reset();
    test_full_map();
    test_start_hold();
    test_reset_midrun();
    checkOutput();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
